hazard_stall_ctrl: RTL and testbench

//  Pipeline hazard sequencer for the 5-stage RV32E core. Detects load-use hazards,

---
 rtl/hazard_stall_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Hazard sequencer for the 5-stage RV32E pipeline: load-use bubbles, branch flushes,
// data-memory wait holds with timeout->halt. Optional perf counters: HZ_PERF_CNT_EN.
module hazard_stall_ctrl #(
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              ex_memread_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              branch_taken_i,
  input  logic              mem_req_i,
  input  logic              mem_ready_i,
  output logic              hazard_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_flush_o,
  output logic              pipe_hold_o,
  output logic              timeout_o,
  output logic              error_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       flush_cnt_o
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             lu, wt;

  assign lu = id_valid_i & ex_memread_i & (ex_rd_i != '0) &
              ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
  assign wt = mem_req_i & ~mem_ready_i;

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    hazard_o     = 1'b0;
    pc_write_o   = 1'b1;
    ifid_write_o = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    pipe_hold_o  = 1'b0;
    timeout_o    = 1'b0;
    error_o      = 1'b0;

    if (rst_i) begin
      hazard_o     = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      state_d      = RUN;
      wait_cnt_d   = '0;
    end else if (state_q == HALT) begin
      hazard_o     = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      pipe_hold_o  = 1'b1;
      error_o      = 1'b1;
    end else if (wt) begin
      // Stage registers are frozen, so branch/load-use wait until the hold drops.
      pipe_hold_o  = 1'b1;
      pc_write_o   = 1'b0;
      ifid_write_o = 1'b0;
      if (state_q == RUN) begin
        state_d    = MEM_WAIT;
        wait_cnt_d = CNT_W'(1);
      end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
        timeout_o  = 1'b1;
        state_d    = HALT;
      end else if (wait_cnt_q < CNT_W'(MAX_WAIT)) begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
      end
    end else begin
      state_d    = RUN;
      wait_cnt_d = '0;
      if (branch_taken_i) begin
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
        hazard_o     = 1'b1;
      end else if (lu) begin
        hazard_o     = 1'b1;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic        active;

  // Actions are only taken when not halted and not holding on memory.
  assign active = (state_q != HALT) & ~wt;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (active & branch_taken_i)   flush_cnt_d = flush_cnt_q + 32'd1;
    else if (active & lu)          stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: stimulus pushes expected outputs from a
// behavioural model, a negedge monitor pops and compares them.
module tb_hazard_stall_ctrl;

  localparam int MAX_WAIT = 15;

  typedef struct {
    logic        hazard, pc_write, ifid_write, ifid_flush, idex_flush;
    logic        hold, timeout, error;
    logic [31:0] stall, flush;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_i, id_valid_i, ex_memread_i, branch_taken_i, mem_req_i, mem_ready_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       hazard_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_flush_o;
  logic       pipe_hold_o, timeout_o, error_o;
  logic [31:0] stall_cnt_o, flush_cnt_o;

  hazard_stall_ctrl #(.REG_AW(5), .MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i),
    .id_rs2_i(id_rs2_i), .ex_memread_i(ex_memread_i), .ex_rd_i(ex_rd_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ready_i(mem_ready_i),
    .hazard_o(hazard_o), .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o), .pipe_hold_o(pipe_hold_o),
    .timeout_o(timeout_o), .error_o(error_o), .stall_cnt_o(stall_cnt_o),
    .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model: consecutive wait-cycle count, halt flag, event counters.
  int          m_waits  = 0;
  bit          m_halted = 1'b0;
  logic [31:0] m_stall  = '0;
  logic [31:0] m_flush  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit vld, input int rs1, input int rs2,
                       input bit mr, input int rd, input bit br, input bit req, input bit rdy);
    exp_t e;
    bit   lu, wt;
    @(posedge clk_i);
    #1;
    rst_i = rst; id_valid_i = vld; id_rs1_i = 5'(rs1); id_rs2_i = 5'(rs2);
    ex_memread_i = mr; ex_rd_i = 5'(rd); branch_taken_i = br;
    mem_req_i = req; mem_ready_i = rdy;

    e = '{hazard:0, pc_write:1, ifid_write:1, ifid_flush:0, idex_flush:0,
          hold:0, timeout:0, error:0, stall:32'd0, flush:32'd0};
`ifdef HZ_PERF_CNT_EN
    e.stall = m_stall;
    e.flush = m_flush;
`endif
    lu = vld && mr && rd != 0 && (rd == rs1 || rd == rs2);
    wt = req && !rdy;
    if (rst) begin
      e.hazard = 1; e.pc_write = 0; e.ifid_write = 0;
      m_halted = 0; m_waits = 0; m_stall = '0; m_flush = '0;
    end else if (m_halted) begin
      e.hazard = 1; e.pc_write = 0; e.ifid_write = 0; e.hold = 1; e.error = 1;
    end else if (wt) begin
      m_waits++;
      e.hold = 1; e.pc_write = 0; e.ifid_write = 0;
      if (m_waits == MAX_WAIT + 1) begin
        e.timeout = 1;
        m_halted  = 1;
      end
    end else begin
      m_waits = 0;
      if (br) begin
        e.ifid_flush = 1; e.idex_flush = 1; e.hazard = 1;
        m_flush = m_flush + 32'd1;
      end else if (lu) begin
        e.hazard = 1; e.pc_write = 0; e.ifid_write = 0;
        m_stall = m_stall + 32'd1;
      end
    end
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("hazard",     32'(hazard_o),     32'(e.hazard));
        check("pc_write",   32'(pc_write_o),   32'(e.pc_write));
        check("ifid_write", 32'(ifid_write_o), 32'(e.ifid_write));
        check("ifid_flush", 32'(ifid_flush_o), 32'(e.ifid_flush));
        check("idex_flush", 32'(idex_flush_o), 32'(e.idex_flush));
        check("pipe_hold",  32'(pipe_hold_o),  32'(e.hold));
        check("timeout",    32'(timeout_o),    32'(e.timeout));
        check("error",      32'(error_o),      32'(e.error));
        check("stall_cnt",  stall_cnt_o,       e.stall);
        check("flush_cnt",  flush_cnt_o,       e.flush);
      end
    end
  end

  initial begin : stimulus
    bit req, rdy, rst;
    int budget;
    rst_i = 1; id_valid_i = 0; id_rs1_i = 0; id_rs2_i = 0; ex_memread_i = 0;
    ex_rd_i = 0; branch_taken_i = 0; mem_req_i = 0; mem_ready_i = 0;

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 5, 0, 1, 5, 0, 0, 0);
    // Load-use on rs1, then load leaves EX.
    drive(0, 1, 5, 7, 1, 5, 0, 0, 0);
    drive(0, 1, 5, 7, 0, 0, 0, 0, 0);
    // Load to x0 never stalls.
    drive(0, 1, 3, 0, 1, 0, 0, 0, 0);
    // Branch beats load-use.
    drive(0, 1, 6, 9, 1, 9, 1, 0, 0);
    drive(0, 1, 1, 2, 0, 0, 0, 0, 0);
    // Three wait cycles, then ready with a pending load-use.
    repeat (3) drive(0, 1, 4, 4, 1, 4, 1, 1, 0);
    drive(0, 1, 4, 4, 1, 4, 0, 1, 1);
    drive(0, 1, 4, 4, 0, 0, 0, 0, 0);
    // Timeout on the 16th wait cycle, then halted until reset.
    repeat (MAX_WAIT + 1) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) drive(0, 1, 2, 2, 1, 2, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 1, 8, 3, 1, 3, 0, 0, 0);
    // Reset in the middle of a wait.
    repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if (m_waits > 0 && !m_halted) begin
        req = 1;
        rdy = ($urandom % 5 == 0);
      end else begin
        req = ($urandom % 3 == 0);
        rdy = ($urandom % 2 == 0);
      end
      rst = m_halted ? ($urandom % 6 == 0) : ($urandom % 200 == 0);
      drive(rst, $urandom % 4 != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom % 2 == 0, $urandom_range(0, 3), $urandom % 5 == 0, req, rdy);
    end

    budget = 20;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk_i);
      budget--;
    end
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
